// File: rtl/alarm_pkg.sv
// Shared types and field widths for the alarm controller slice.
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

endpackage

// File: rtl/alarm_controller_sec_timebase.sv
// Second timebase: a 1 ms prescaler cascaded into a tick counter.
// sec_pulse is high for one cycle on the last clock of each second.
// 'clear' restarts the second so that intervals measured from it are exact.
module sec_timebase #(
    parameter int CLOCK_FREQ_1KHZ = 50000,
    parameter int TICKS_PER_SEC   = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic sec_pulse
);

    localparam int PRE_W  = $clog2(CLOCK_FREQ_1KHZ + 1);
    localparam int TICK_W = $clog2(TICKS_PER_SEC + 1);

    logic [PRE_W-1:0]  pre_q;
    logic [TICK_W-1:0] tick_q;
    logic              ms_tick;

    assign ms_tick   = (pre_q == PRE_W'(CLOCK_FREQ_1KHZ - 1));
    assign sec_pulse = ms_tick && (tick_q == TICK_W'(TICKS_PER_SEC - 1));

    // Prescaler: wraps every CLOCK_FREQ_1KHZ cycles.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            pre_q <= '0;
        end else if (ms_tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Millisecond tick counter: wraps every TICKS_PER_SEC ticks.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            tick_q <= '0;
        end else if (sec_pulse) begin
            tick_q <= '0;
        end else if (ms_tick) begin
            tick_q <= tick_q + TICK_W'(1);
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: compares time-of-day against the alarm time and runs
// the ring / snooze / timeout sequence. 'ring' feeds the Blinker enable.
// Optional build macro ALARM_SNOOZE_LIMIT_EN caps snoozes at MAX_SNOOZE.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | disarmed (alarm_on low)
// ARMED   | waiting for the alarm minute to start
// RINGING | ring high; stop, snooze or timeout leaves
// SNOOZE  | ring paused; re-rings after SNOOZE_S seconds unless stopped
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int CLOCK_FREQ_1KHZ = 50000,
    parameter int TICKS_PER_SEC   = 1000,
    parameter int RING_TIMEOUT_S  = 60,
    parameter int SNOOZE_S        = 300,
    parameter int MAX_SNOOZE      = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alarm_on,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic              ring,
    output logic              snoozing,
    output logic [1:0]        state
);

    localparam int MAX_S = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
    localparam int CNT_W = $clog2(MAX_S + 1);

    state_t           state_q, state_d;
    logic             stop_q, snooze_q, match_q;
    logic             match, match_edge, stop_edge, snooze_edge;
    logic             snooze_ok, ring_done, snooze_done;
    logic             sec_pulse, tb_clear;
    logic [CNT_W-1:0] secs_q;

    assign match       = (cur_hour == alarm_hour) && (cur_min == alarm_min) &&
                         (cur_sec == '0);
    assign match_edge  = match & ~match_q;
    assign stop_edge   = stop_btn & ~stop_q;
    assign snooze_edge = snooze_btn & ~snooze_q;

    // The exit happens on the same sec_pulse that brings the count to the limit.
    assign ring_done   = sec_pulse && (secs_q == CNT_W'(RING_TIMEOUT_S - 1));
    assign snooze_done = sec_pulse && (secs_q == CNT_W'(SNOOZE_S - 1));

    // Restart the second on every entry into a timed state.
    assign tb_clear = ((state_d == RINGING) && (state_q != RINGING)) ||
                      ((state_d == SNOOZE)  && (state_q != SNOOZE));

    sec_timebase #(
        .CLOCK_FREQ_1KHZ (CLOCK_FREQ_1KHZ),
        .TICKS_PER_SEC   (TICKS_PER_SEC)
    ) u_timebase (
        .clock     (clock),
        .reset     (reset),
        .clear     (tb_clear),
        .sec_pulse (sec_pulse)
    );

    // Edge-detect registers for both buttons and the minute match.
    always_ff @(posedge clock) begin
        if (reset) begin
            stop_q   <= 1'b0;
            snooze_q <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            stop_q   <= stop_btn;
            snooze_q <= snooze_btn;
            match_q  <= match;
        end
    end

    // Seconds elapsed in the current timed state; saturates instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset || tb_clear) begin
            secs_q <= '0;
        end else if (sec_pulse && (secs_q != CNT_W'(MAX_S))) begin
            secs_q <= secs_q + CNT_W'(1);
        end
    end

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int SNZ_W = $clog2(MAX_SNOOZE + 1);
    logic [SNZ_W-1:0] snz_cnt_q;

    // Snoozes taken since the alarm was last armed.
    always_ff @(posedge clock) begin
        if (reset) begin
            snz_cnt_q <= '0;
        end else if ((state_q == IDLE) || ((state_d == ARMED) && (state_q != ARMED))) begin
            snz_cnt_q <= '0;
        end else if ((state_q == RINGING) && (state_d == SNOOZE)) begin
            snz_cnt_q <= snz_cnt_q + SNZ_W'(1);
        end
    end

    assign snooze_ok = (snz_cnt_q != SNZ_W'(MAX_SNOOZE));
`else
    assign snooze_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; disarm overrides everything, stop beats snooze.
    always_comb begin
        state_d = state_q;
        if (!alarm_on) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   if (match_edge) state_d = RINGING;
                RINGING: begin
                    if (stop_edge)                     state_d = ARMED;
                    else if (snooze_edge && snooze_ok) state_d = SNOOZE;
                    else if (ring_done)                state_d = ARMED;
                end
                SNOOZE: begin
                    if (stop_edge)        state_d = ARMED;
                    else if (snooze_done) state_d = RINGING;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ring     = (state_q == RINGING);
    assign snoozing = (state_q == SNOOZE);
    assign state    = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios followed by random
// stimulus, all checked against a cycle-count reference model.
module tb_alarm_controller;

    localparam int CF  = 2;
    localparam int TPS = 5;
    localparam int RT  = 3;
    localparam int SN  = 2;
    localparam int MS  = 3;
    localparam int CPS = CF * TPS;

    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

    logic       clock = 1'b0;
    logic       reset, alarm_on, snooze_btn, stop_btn;
    logic [4:0] cur_hour, alarm_hour;
    logic [5:0] cur_min, cur_sec, alarm_min;
    logic       ring, snoozing;
    logic [1:0] state;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    int m_st, m_el, m_snz;
    bit m_stop_q, m_snz_q, m_match_q;

    always #5 clock = ~clock;

    alarm_controller #(
        .CLOCK_FREQ_1KHZ (CF),
        .TICKS_PER_SEC   (TPS),
        .RING_TIMEOUT_S  (RT),
        .SNOOZE_S        (SN),
        .MAX_SNOOZE      (MS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .alarm_on   (alarm_on),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .snooze_btn (snooze_btn),
        .stop_btn   (stop_btn),
        .ring       (ring),
        .snoozing   (snoozing),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT samples.
    task automatic model_step();
        bit stop_e, snz_e, match_now, match_e, snz_ok;
        int nxt;
        if (reset) begin
            m_st = M_IDLE; m_el = 0; m_snz = 0;
            m_stop_q = 0; m_snz_q = 0; m_match_q = 0;
            return;
        end
        match_now = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 0);
        stop_e    = stop_btn && !m_stop_q;
        snz_e     = snooze_btn && !m_snz_q;
        match_e   = match_now && !m_match_q;
        m_stop_q  = stop_btn;
        m_snz_q   = snooze_btn;
        m_match_q = match_now;
`ifdef ALARM_SNOOZE_LIMIT_EN
        snz_ok = (m_snz < MS);
`else
        snz_ok = 1'b1;
`endif
        nxt = m_st;
        if (!alarm_on) nxt = M_IDLE;
        else if (m_st == M_IDLE) nxt = M_ARMED;
        else if (m_st == M_ARMED) begin
            if (match_e) nxt = M_RING;
        end else if (m_st == M_RING) begin
            if (stop_e) nxt = M_ARMED;
            else if (snz_e && snz_ok) nxt = M_SNZ;
            else if (m_el == RT * CPS - 1) nxt = M_ARMED;
        end else begin
            if (stop_e) nxt = M_ARMED;
            else if (m_el == SN * CPS - 1) nxt = M_RING;
        end
        if (m_st == M_RING && nxt == M_SNZ) m_snz++;
        if (nxt == M_IDLE || (nxt == M_ARMED && m_st != M_ARMED)) m_snz = 0;
        m_el = (nxt != m_st) ? 0 : m_el + 1;
        m_st = nxt;
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check({tag, ":state"}, 32'(state), 32'(m_st));
        check({tag, ":ring"}, 32'(ring), 32'(m_st == M_RING));
        check({tag, ":snoozing"}, 32'(snoozing), 32'(m_st == M_SNZ));
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    // Step time off and back onto 07:30:00 to create a fresh match edge.
    task automatic trigger(input string tag);
        set_time(7, 30, 1);
        cycle({tag, "_pre"});
        set_time(7, 30, 0);
        cycle(tag);
        check({tag, ":ring_on"}, 32'(ring), 32'd1);
    endtask

    task automatic press_snooze(input string tag);
        snooze_btn = 1'b1;
        cycle(tag);
        snooze_btn = 1'b0;
    endtask

    task automatic wait_ring(input string tag);
        int n = 0;
        while (!ring && n < 25) begin
            cycle(tag);
            n++;
        end
        check({tag, ":re_ring"}, 32'(ring), 32'd1);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; alarm_on = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        alarm_hour = 5'd7; alarm_min = 6'd30;
        set_time(7, 29, 59);
        #1;
        cycle("reset0");
        cycle("reset1");
        check("reset_state", 32'(state), M_IDLE);
        check("reset_ring", 32'(ring), 32'd0);

        // arm and trigger
        reset = 1'b0; alarm_on = 1'b1;
        cycle("arm");
        check("armed", 32'(state), M_ARMED);
        cycle("armed_wait");
        trigger("trig");
        check("trig_state", 32'(state), M_RING);

        // stop, then hold 07:30:00: must not re-trigger
        stop_btn = 1'b1;
        cycle("stop");
        stop_btn = 1'b0;
        check("stop_ring", 32'(ring), 32'd0);
        for (int i = 0; i < 15; i++) cycle("hold_min");
        check("no_retrigger", 32'(state), M_ARMED);

        // timeout after exactly RT seconds
        trigger("to_trig");
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            cycle("timeout");
            if (ring) cnt++;
        end
        check("timeout_len", cnt, RT * CPS);
        check("timeout_state", 32'(state), M_ARMED);

        // snooze cycle
        trigger("snz_trig");
        cycle("snz_ring");
        press_snooze("snz_press");
        cnt = snoozing ? 1 : 0;
        for (int i = 0; i < 24; i++) begin
            cycle("snz_wait");
            if (snoozing) cnt++;
        end
        check("snooze_len", cnt, SN * CPS);
        check("snooze_rering", 32'(ring), 32'd1);

        // stop and snooze together: stop wins
        stop_btn = 1'b1; snooze_btn = 1'b1;
        cycle("both");
        stop_btn = 1'b0; snooze_btn = 1'b0;
        check("both_state", 32'(state), M_ARMED);

        // disarm during snooze
        trigger("dis_trig");
        press_snooze("dis_snz");
        for (int i = 0; i < 3; i++) cycle("dis_wait");
        alarm_on = 1'b0;
        cycle("disarm");
        check("disarm_state", 32'(state), M_IDLE);
        alarm_on = 1'b1;
        cycle("rearm");

        // reset during ringing
        trigger("rst_trig");
        reset = 1'b1;
        cycle("rst_ring");
        check("rst_state", 32'(state), M_IDLE);
        check("rst_ring_off", 32'(ring), 32'd0);
        reset = 1'b0;
        cycle("rst_rel");

`ifdef ALARM_SNOOZE_LIMIT_EN
        // snooze limit: the fourth snooze edge is ignored
        trigger("lim_trig");
        for (int k = 0; k < MS; k++) begin
            press_snooze("lim_snz");
            wait_ring("lim_wait");
        end
        cnt = 1;
        press_snooze("lim_4th");
        if (ring) cnt++;
        for (int i = 0; i < 35; i++) begin
            cycle("lim_timeout");
            if (ring) cnt++;
        end
        check("limit_ring_len", cnt, RT * CPS);
        check("limit_state", 32'(state), M_ARMED);
`endif

        // random phase
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            alarm_on   = ($urandom_range(0, 59) != 0);
            stop_btn   = ($urandom_range(0, 39) == 0);
            snooze_btn = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                alarm_hour = 5'($urandom_range(0, 23));
                alarm_min  = 6'($urandom_range(0, 59));
            end
            if ($urandom_range(0, 3) == 0)
                set_time(int'(alarm_hour), int'(alarm_min), 0);
            else
                set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
